// File: rtl/div_share_ctrl_pkg.sv
// rtl/div_share_ctrl_pkg.sv - shared types for the divider-sharing controller
//
// Purpose: divider operation encoding, controller FSM states and the default
//          requester count used by div_share_ctrl and its arbiter.
// Ports:   none (package).

package div_share_ctrl_pkg;

  localparam int DIV_SHARE_N_REQ = 4;

  typedef enum logic [1:0] {
    DOP_DIV  = 2'd0,
    DOP_DIVU = 2'd1,
    DOP_REM  = 2'd2
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } div_share_state_t;

endpackage

// File: rtl/div_share_ctrl_rr_arbiter.sv
// rtl/div_share_ctrl_rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: grants the first asserted request at or after ptr_i, wrapping
//          modulo N_REQ. Reusable for any shared-resource controller.
// Ports:
//   req_i      in  N_REQ  request vector
//   ptr_i      in  IDX_W  highest-priority index
//   gnt_o      out N_REQ  one-hot grant
//   gnt_idx_o  out IDX_W  binary index of the grant
//   gnt_any_o  out 1      some request is granted

module div_share_ctrl_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_any_o
);

  int cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    cand      = 0;
    // Walk indices in priority order ptr, ptr+1, ... and keep the first hit.
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!gnt_any_o && req_i[cand[IDX_W-1:0]]) begin
        gnt_any_o                = 1'b1;
        gnt_o[cand[IDX_W-1:0]]   = 1'b1;
        gnt_idx_o                = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// rtl/div_share_ctrl.sv - time-multiplexes one iterative divider among N_REQ FUs
//
// Purpose: round-robin arbitration of division requests onto a single divider,
//          one outstanding division at a time; divide-by-zero is answered
//          locally (q = all ones, r = a) without starting the divider.
// Optional: DIV_SHARE_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYC cycles
//          that answers with q = all ones, r = a and rsp_err_o = 1.
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   req_valid_i/ready_o     per-requester request handshake (ready one-hot)
//   req_a_i/b_i/op_i        packed per-requester operands and div_op_t
//   rsp_valid_o/ready_i     per-requester response handshake (valid one-hot)
//   rsp_q_o/r_o/err_o       shared response bus
//   div_a_o/b_o/op_o        operands to the divider, driven from latches
//   div_in_valid_o          divider start pulse
//   div_q_i/r_i/valid_i     divider result and done pulse
//   busy_o                  controller not in IDLE

module div_share_ctrl
  import div_share_ctrl_pkg::*;
#(
  parameter int N_REQ       = DIV_SHARE_N_REQ,
  parameter int N_BITS      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*N_BITS-1:0] req_a_i,
  input  logic [N_REQ*N_BITS-1:0] req_b_i,
  input  logic [N_REQ*2-1:0]      req_op_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [N_REQ-1:0]        rsp_valid_o,
  input  logic [N_REQ-1:0]        rsp_ready_i,
  output logic [N_BITS-1:0]       rsp_q_o,
  output logic [N_BITS-1:0]       rsp_r_o,
  output logic                    rsp_err_o,
  output logic [N_BITS-1:0]       div_a_o,
  output logic [N_BITS-1:0]       div_b_o,
  output logic [1:0]              div_op_o,
  output logic                    div_in_valid_o,
  input  logic [N_BITS-1:0]       div_q_i,
  input  logic [N_BITS-1:0]       div_r_i,
  input  logic                    div_valid_i,
  output logic                    busy_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  div_share_state_t  state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, id_q, gnt_idx, ptr_nxt;
  logic [N_REQ-1:0]  gnt;
  logic              gnt_any;
  logic [N_BITS-1:0] a_q, b_q, q_q, r_q;
  logic [N_BITS-1:0] sel_a, sel_b;
  logic [1:0]        op_q, sel_op;
  logic              div_zero, timeout_hit;

  div_share_ctrl_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  assign sel_a    = req_a_i[int'(gnt_idx)*N_BITS +: N_BITS];
  assign sel_b    = req_b_i[int'(gnt_idx)*N_BITS +: N_BITS];
  assign sel_op   = req_op_i[int'(gnt_idx)*2 +: 2];
  assign div_zero = (sel_b == '0);
  assign ptr_nxt  = (id_q == IDX_W'(N_REQ - 1)) ? '0 : id_q + IDX_W'(1);

`ifdef DIV_SHARE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             err_q;

  assign timeout_hit = (state_q == WAIT) && !div_valid_i &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign rsp_err_o   = err_q && (state_q == RESP);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == ISSUE)     wait_cnt_q <= '0;
      else if (state_q == WAIT) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      if (state_q == IDLE)      err_q <= 1'b0;
      else if (timeout_hit)     err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
  assign timeout_hit    = 1'b0;
  assign rsp_err_o      = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    req_ready_o    = '0;
    rsp_valid_o    = '0;
    div_in_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        // Gate with reset so no accept is signalled while reset is held.
        if (gnt_any && rst_n_i) begin
          req_ready_o = gnt;
          state_d     = div_zero ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        div_in_valid_o = 1'b1;
        state_d        = WAIT;
      end
      WAIT: begin
        if (div_valid_i || timeout_hit) state_d = RESP;
      end
      RESP: begin
        rsp_valid_o[id_q] = 1'b1;
        if (rsp_ready_i[id_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            a_q  <= sel_a;
            b_q  <= sel_b;
            op_q <= sel_op;
            id_q <= gnt_idx;
            if (div_zero) begin
              q_q <= '1;
              r_q <= sel_a;
            end
          end
        end
        WAIT: begin
          if (div_valid_i) begin
            q_q <= div_q_i;
            r_q <= div_r_i;
          end else if (timeout_hit) begin
            q_q <= '1;
            r_q <= a_q;
          end
        end
        RESP: begin
          if (rsp_ready_i[id_q]) ptr_q <= ptr_nxt;
        end
        default: ;
      endcase
    end
  end

  assign rsp_q_o  = q_q;
  assign rsp_r_o  = r_q;
  assign div_a_o  = a_q;
  assign div_b_o  = b_q;
  assign div_op_o = op_q;
  assign busy_o   = (state_q != IDLE);

endmodule
